write_command_register: RTL and testbench

WRITE_COMMAND_REGISTER -- requirements
Module: write_command_register

---
 rtl/write_command_register_pkg.sv | 9 +
 rtl/write_command_register_if.sv | 21 ++
 rtl/write_command_register.sv | 71 +++++++
 tb/tb_write_command_register.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/write_command_register_pkg.sv
// write_command_register_pkg: shared FSM states, address selects and status bit positions.
package write_command_register_pkg;
  typedef enum logic [1:0] {EMPTY, ONE, TWO} wcrState_t;
  localparam logic ADDR_CMD = 1'b0;
  localparam logic ADDR_STATUS = 1'b1;
  localparam int STAT_PENDING = 0;
  localparam int STAT_FULL = 1;
  localparam int STAT_OVERFLOW = 2;
endpackage

// File: rtl/write_command_register_if.sv
// write_command_register_if: processor register port plus I/O command handoff.
interface write_command_register_if #(parameter int DATA_WIDTH = 32);
  logic Sys_RegSelect;
  logic Sys_AddrSel;
  logic Sys_WrEn;
  logic Sys_RdEn;
  logic [DATA_WIDTH-1:0] Sys_WrData;
  logic [DATA_WIDTH-1:0] Sys_RdData;
  logic Sys_Irq;
  logic [DATA_WIDTH-1:0] IO_Data;
  logic IO_Valid;
  logic IO_Ack;
  modport master (
    output Sys_RegSelect, Sys_AddrSel, Sys_WrEn, Sys_RdEn, Sys_WrData, IO_Ack,
    input Sys_RdData, Sys_Irq, IO_Data, IO_Valid
  );
  modport slave (
    input Sys_RegSelect, Sys_AddrSel, Sys_WrEn, Sys_RdEn, Sys_WrData, IO_Ack,
    output Sys_RdData, Sys_Irq, IO_Data, IO_Valid
  );
endinterface

// File: rtl/write_command_register.sv
// write_command_register: two-entry command FIFO from processor writes to I/O logic.
// Define WCR_OVERFLOW_DETECT_EN to add the sticky overflow flag, status bit 2 and Sys_Irq.
module write_command_register
  import write_command_register_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input logic Clock,
  input logic Reset,
  write_command_register_if.slave bus
);
  wcrState_t state, stateNext;
  logic [DATA_WIDTH-1:0] outData, outNext, holdData, holdNext, status;
  logic accept, consume, overflow;
  assign accept = bus.Sys_WrEn & bus.Sys_RegSelect & (bus.Sys_AddrSel == ADDR_CMD);
  assign consume = bus.IO_Ack & bus.IO_Valid;
  always_ff @(posedge Clock or negedge Reset)
    if (!Reset) begin
      state <= EMPTY;
      outData <= RESET_VALUE;
      holdData <= '0;
    end else begin
      state <= stateNext;
      outData <= outNext;
      holdData <= holdNext;
    end
  // A write while both stages are occupied and nothing drains is dropped
  always_comb begin
    stateNext = state;
    outNext = outData;
    holdNext = holdData;
    case (state)
      EMPTY: begin
        stateNext = accept ? ONE : EMPTY;
        outNext = accept ? bus.Sys_WrData : outData;
      end
      ONE: begin
        stateNext = accept ? (consume ? ONE : TWO) : (consume ? EMPTY : ONE);
        outNext = (accept & consume) ? bus.Sys_WrData : outData;
        holdNext = (accept & ~consume) ? bus.Sys_WrData : holdData;
      end
      TWO: begin
        stateNext = (consume & ~accept) ? ONE : TWO;
        outNext = consume ? holdData : outData;
        holdNext = (consume & accept) ? bus.Sys_WrData : holdData;
      end
      default: stateNext = EMPTY;
    endcase
  end
`ifdef WCR_OVERFLOW_DETECT_EN
  logic statusRead, ovfEvent;
  assign statusRead = bus.Sys_RdEn & bus.Sys_RegSelect & (bus.Sys_AddrSel == ADDR_STATUS);
  assign ovfEvent = (state == TWO) & accept & ~consume;
  always_ff @(posedge Clock or negedge Reset)
    if (!Reset) overflow <= 1'b0;
    else overflow <= ovfEvent | (overflow & ~statusRead);
`else
  assign overflow = 1'b0;
`endif
  always_comb begin
    status = '0;
    status[STAT_PENDING] = state != EMPTY;
    status[STAT_FULL] = state == TWO;
    status[STAT_OVERFLOW] = overflow;
  end
  assign bus.IO_Valid = state != EMPTY;
  assign bus.IO_Data = outData;
  assign bus.Sys_Irq = overflow;
  assign bus.Sys_RdData = (bus.Sys_AddrSel == ADDR_STATUS) ? status : outData;
endmodule

// File: tb/tb_write_command_register.sv
// tb_write_command_register: randomized + directed scoreboard bench against a queue-based model.
module tb_write_command_register;
  localparam int W = 32;
  localparam logic [W-1:0] RV = 32'hDEAD_0000;
`ifdef WCR_OVERFLOW_DETECT_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif
  typedef struct {
    bit valid;
    bit irq;
    bit known;
    logic [W-1:0] data;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int vectors = 0;
  int fails = 0;
  logic [W-1:0] model[$];
  bit ovf = 1'b0;
  bit fresh = 1'b1;
  exp_t cycQ[$];
  exp_t rdQ[$];
  logic [W-1:0] ackQ[$];
  write_command_register_if #(.DATA_WIDTH(W)) bus ();
  write_command_register #(.DATA_WIDTH(W), .RESET_VALUE(RV)) dut (
    .Clock(clk),
    .Reset(rst_n),
    .bus(bus.slave)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic logic [W-1:0] statusWord();
    logic [W-1:0] s = '0;
    s[0] = model.size() != 0;
    s[1] = model.size() == 2;
    s[2] = OVF_EN && ovf;
    return s;
  endfunction
  function automatic exp_t outputsNow();
    exp_t e;
    e.valid = model.size() != 0;
    e.irq = OVF_EN && ovf;
    e.known = e.valid || fresh;
    e.data = e.valid ? model[0] : RV;
    return e;
  endfunction
  task automatic drive(input bit sel, input bit addr, input bit wr, input bit rd, input bit ack, input logic [W-1:0] d);
    bus.Sys_RegSelect = sel;
    bus.Sys_AddrSel = addr;
    bus.Sys_WrEn = wr;
    bus.Sys_RdEn = rd;
    bus.Sys_WrData = d;
    bus.IO_Ack = ack;
  endtask
  task automatic cycle(input bit sel, input bit addr, input bit wr, input bit rd, input bit ack, input logic [W-1:0] d);
    exp_t e, r;
    bit acc, cons;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(sel, addr, wr, rd, ack, d);
    e = outputsNow();
    cycQ.push_back(e);
    if (sel && rd) begin
      r = e;
      r.known = addr || e.known;
      r.data = addr ? statusWord() : e.data;
      rdQ.push_back(r);
    end
    cons = ack && model.size() != 0;
    acc = sel && wr && !addr;
    if (cons) ackQ.push_back(model.pop_front());
    if (sel && rd && addr) ovf = 1'b0;
    if (acc) begin
      fresh = 1'b0;
      if (model.size() < 2) model.push_back(d);
      else ovf = 1'b1;
    end
  endtask
  task automatic doReset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, '0);
    model.delete();
    ovf = 1'b0;
    fresh = 1'b1;
    cycQ.push_back(outputsNow());
  endtask
  task automatic wrCmd(input logic [W-1:0] d, input bit ack);
    cycle(1, 0, 1, 0, ack, d);
  endtask
  task automatic rdStat();
    cycle(1, 1, 0, 1, 0, '0);
  endtask
  task automatic ackOnly();
    cycle(0, 0, 0, 0, 1, '0);
  endtask
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (cycQ.size() != 0) begin
        e = cycQ.pop_front();
        chk("io_valid", W'(bus.IO_Valid), W'(e.valid));
        chk("sys_irq", W'(bus.Sys_Irq), W'(e.irq));
        if (e.known) chk("io_data", bus.IO_Data, e.data);
      end
      if (bus.Sys_RegSelect === 1'b1 && bus.Sys_RdEn === 1'b1) begin
        if (rdQ.size() == 0) chk("unexpected_read", 1, 0);
        else begin
          e = rdQ.pop_front();
          if (e.known) chk(bus.Sys_AddrSel ? "rd_status" : "rd_cmd", bus.Sys_RdData, e.data);
        end
      end
      if (bus.IO_Valid === 1'b1 && bus.IO_Ack === 1'b1) begin
        if (ackQ.size() == 0) chk("unexpected_consume", 1, 0);
        else chk("consumed_word", bus.IO_Data, ackQ.pop_front());
      end
    end
  end
  initial begin
    drive(0, 0, 0, 0, 0, '0);
    doReset();
    rdStat();
    cycle(1, 0, 0, 1, 0, '0);
    wrCmd(32'hA5A5_0001, 0);
    rdStat();
    cycle(1, 0, 0, 1, 0, '0);
    ackOnly();
    rdStat();
    wrCmd(32'h11, 0);
    wrCmd(32'h22, 0);
    wrCmd(32'h33, 0);
    rdStat();
    ackOnly();
    ackOnly();
    rdStat();
    ackOnly();
    doReset();
    wrCmd(32'h11, 0);
    wrCmd(32'h22, 0);
    wrCmd(32'h33, 1);
    rdStat();
    ackOnly();
    ackOnly();
    rdStat();
    wrCmd(32'h11, 0);
    wrCmd(32'h22, 0);
    wrCmd(32'h33, 0);
    cycle(1, 0, 1, 1, 0, 32'h44);
    cycle(1, 1, 0, 1, 0, '0);
    rdStat();
    rdStat();
    wrCmd(32'h55, 0);
    doReset();
    rdStat();
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 199) == 0) doReset();
      else cycle($urandom_range(0, 7) != 0, $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0, $urandom);
    end
    for (int i = 0; i < 4; i++) ackOnly();
    @(negedge clk);
    #1;
    chk("leftover_cycles", W'(cycQ.size()), 0);
    chk("leftover_reads", W'(rdQ.size()), 0);
    chk("leftover_consumes", W'(ackQ.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule
